// File: rtl/avalon_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_io_bridge
//  Description : Avalon-MM slave front end for the input controller register
//                port. Turns one held Avalon read/write into a single-cycle
//                controller access, waits for completion (with a write
//                timeout), returns read data, raises a sticky error flag and
//                registers the controller interrupt toward the CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_io_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] avs_address,
    input  logic                  avs_write,
    input  logic                  avs_read,
    input  logic [DATA_WIDTH-1:0] avs_writedata,
    output logic [DATA_WIDTH-1:0] avs_readdata,
    output logic                  avs_waitrequest,
    output logic                  ctl_we,
    output logic [ADDR_WIDTH-1:0] ctl_addr,
    output logic [DATA_WIDTH-1:0] ctl_wr_data,
    input  logic [DATA_WIDTH-1:0] ctl_rd_data,
    input  logic                  ctl_done,
    input  logic                  ctl_irq,
    output logic                  irq,
    output logic                  err,
    input  logic                  err_clr
);

    // Counter is one bit wider than needed so TIMEOUT_CYCLES-1 always fits.
    localparam int                c_cnt_w    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_STROBE = 3'd1,
        S_WR_WAIT   = 3'd2,
        S_RD_ADDR   = 3'd3,
        S_RD_CAPT   = 3'd4,
        S_ACK       = 3'd5
    } state_t;

    state_t                r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_waitrequest;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] r_readdata;
    logic                  r_irq;
    logic                  r_err;

    // Transfer sequencer; every output is registered, so waitrequest is
    // dropped on the edge that enters ACK and restored on the edge leaving it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_waitrequest <= 1'b1;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wr_data     <= '0;
            r_readdata    <= '0;
            r_err         <= 1'b0;
        end else begin
            r_we          <= 1'b0;
            r_waitrequest <= 1'b1;
            // Clear first so that a set later in this block takes priority.
            if (err_clr) begin
                r_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (avs_write) begin
                        r_addr    <= avs_address;
                        r_wr_data <= avs_writedata;
                        r_we      <= 1'b1;
                        r_state   <= S_WR_STROBE;
                        if (avs_read) begin
                            r_err <= 1'b1;
                        end
                    end else if (avs_read) begin
                        r_addr  <= avs_address;
                        r_state <= S_RD_ADDR;
                    end
                end
                S_WR_STROBE: begin
                    r_cnt <= '0;
                    if (ctl_done) begin
                        r_waitrequest <= 1'b0;
                        r_state       <= S_ACK;
                    end else begin
                        r_state <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (ctl_done) begin
                        r_waitrequest <= 1'b0;
                        r_state       <= S_ACK;
                    end else if (r_cnt == c_cnt_last) begin
                        r_waitrequest <= 1'b0;
                        r_err         <= 1'b1;
                        r_state       <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RD_ADDR: begin
                    r_state <= S_RD_CAPT;
                end
                S_RD_CAPT: begin
                    r_readdata    <= ctl_rd_data;
                    r_waitrequest <= 1'b0;
                    r_state       <= S_ACK;
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Interrupt is simply retimed by one cycle, independent of the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= ctl_irq;
        end
    end

    assign avs_waitrequest = r_waitrequest;
    assign avs_readdata    = r_readdata;
    assign ctl_we          = r_we;
    assign ctl_addr        = r_addr;
    assign ctl_wr_data     = r_wr_data;
    assign irq             = r_irq;
    assign err             = r_err;

endmodule
`default_nettype wire

// File: tb/tb_avalon_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avalon_io_bridge
//  Description : Directed testbench for avalon_io_bridge with a cycle-indexed
//                expectation model built from transaction latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_io_bridge;

    localparam int T = 4;
    localparam int N = 512;

    logic        clk;
    logic        rst_n;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic        avs_read;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        ctl_we;
    logic [1:0]  ctl_addr;
    logic [31:0] ctl_wr_data;
    logic [31:0] ctl_rd_data;
    logic        ctl_done;
    logic        ctl_irq;
    logic        irq;
    logic        err;
    logic        err_clr;

    avalon_io_bridge #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (2),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .avs_address     (avs_address),
        .avs_write       (avs_write),
        .avs_read        (avs_read),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .ctl_we          (ctl_we),
        .ctl_addr        (ctl_addr),
        .ctl_wr_data     (ctl_wr_data),
        .ctl_rd_data     (ctl_rd_data),
        .ctl_done        (ctl_done),
        .ctl_irq         (ctl_irq),
        .irq             (irq),
        .err             (err),
        .err_clr         (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 0;
    bit irq_toggle = 0;
    bit irq_ok = 0;
    logic prev_ctl_irq = 1'b0;

    // Expected outputs per clock period
    bit          exp_wait [N];
    bit          exp_we   [N];
    bit          exp_err  [N];
    logic [1:0]  exp_addr [N];
    logic [31:0] exp_wd   [N];
    logic [31:0] exp_rd   [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s (period %0d): got %h expected %h", nm, cyc, act, req);
        end
    endtask

    function automatic void model_reset(input int c);
        for (int i = c; i < N; i++) begin
            exp_wait[i] = 1'b1; exp_we[i] = 1'b0; exp_err[i] = 1'b0;
            exp_addr[i] = '0;   exp_wd[i] = '0;   exp_rd[i]  = '0;
        end
    endfunction

    // Transaction-level prediction: command visible in IDLE during period c0.
    function automatic void model_cmd(input int c0, input bit wr, input bit rd,
                                      input logic [1:0] a, input logic [31:0] wd,
                                      input logic [31:0] rdv, input int d);
        int  ack;
        bit  timed;
        if (wr) begin
            timed = !(d >= 0 && d <= T);
            ack   = timed ? c0 + 2 + T : c0 + 2 + d;
            if (c0 + 1 < N) exp_we[c0 + 1] = 1'b1;
            for (int i = c0 + 1; i < N; i++) begin
                exp_addr[i] = a;
                exp_wd[i]   = wd;
                if (rd) exp_err[i] = 1'b1;
            end
            if (timed) for (int i = ack; i < N; i++) exp_err[i] = 1'b1;
        end else begin
            ack = c0 + 3;
            for (int i = c0 + 1; i < N; i++) exp_addr[i] = a;
            for (int i = ack; i < N; i++) exp_rd[i] = rdv;
        end
        if (ack < N) exp_wait[ack] = 1'b0;
    endfunction

    function automatic void model_clr(input int c);
        for (int i = c + 1; i < N; i++) exp_err[i] = 1'b0;
    endfunction

    // Per-period comparison against the model
    always @(negedge clk) begin
        if (chk_en && cyc < N) begin
            check("waitrequest", avs_waitrequest, exp_wait[cyc]);
            check("ctl_we",      ctl_we,          exp_we[cyc]);
            check("ctl_addr",    ctl_addr,        exp_addr[cyc]);
            check("ctl_wr_data", ctl_wr_data,     exp_wd[cyc]);
            check("readdata",    avs_readdata,    exp_rd[cyc]);
            check("err",         err,             exp_err[cyc]);
            if (irq_ok) check("irq", irq, prev_ctl_irq);
        end
        prev_ctl_irq <= ctl_irq;
        irq_ok       <= chk_en && rst_n;
    end

    // Interrupt stimulus, toggled while enabled
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (irq_toggle) ctl_irq = ~ctl_irq;
        end
    end

    // One Avalon command; called at posedge+1 and returns at posedge+1 of the
    // period following ACK with the request already removed.
    task automatic cmd(input bit wr, input bit rd, input logic [1:0] a,
                       input logic [31:0] wd, input logic [31:0] rdv,
                       input int d, input int lat_req, input string nm,
                       output logic [31:0] rdo);
        int c0;
        int ackp;
        bit acked;
        c0 = cyc; acked = 0; ackp = 0; rdo = '0;
        avs_write = wr; avs_read = rd; avs_address = a;
        avs_writedata = wd; ctl_rd_data = rdv;
        model_cmd(c0, wr, rd, a, wd, rdv, d);
        for (int p = c0; p < c0 + 40 && !acked; p++) begin
            ctl_done = wr && (d >= 0) && (p == c0 + 1 + d);
            @(negedge clk);
            if (!avs_waitrequest) begin
                acked = 1; ackp = p; rdo = avs_readdata;
            end
            @(posedge clk);
            #1;
        end
        avs_write = 1'b0; avs_read = 1'b0; ctl_done = 1'b0;
        if (!acked) begin
            total++; bad++;
            $display("FAIL %s latency: no ACK within 40 cycles, expected %0d", nm, lat_req);
        end else begin
            check({nm, " latency"}, ackp - c0, lat_req);
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        model_clr(cyc);
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    initial begin
        logic [31:0] rdo;
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdo;
        rst_n = 1'b0; avs_address = '0; avs_write = 1'b0; avs_read = 1'b0;
        avs_writedata = '0; ctl_rd_data = '0; ctl_done = 1'b0; ctl_irq = 1'b0;
        err_clr = 1'b0;
        model_reset(0);
        repeat (3) @(posedge clk);
        #1;
        // Reset values
        check("rst waitrequest", avs_waitrequest, 1);
        check("rst ctl_we",      ctl_we,          0);
        check("rst err",         err,             0);
        check("rst readdata",    avs_readdata,    0);
        check("rst irq",         irq,             0);
        rst_n = 1'b1;
        model_reset(cyc);
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Test 1: reset in the middle of WR_WAIT aborts the write
        avs_write = 1'b1; avs_address = 2'd3; avs_writedata = 32'h0000_0055;
        model_cmd(cyc, 1, 0, 2'd3, 32'h0000_0055, 32'h0, -1);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0; chk_en = 1'b0; avs_write = 1'b0;
        #1;
        check("t1 waitrequest", avs_waitrequest, 1);
        check("t1 ctl_we",      ctl_we,          0);
        check("t1 err",         err,             0);
        check("t1 ctl_addr",    ctl_addr,        0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset(cyc);
        chk_en = 1'b1;

        // Test 2: write, done three cycles after the strobe
        cmd(1, 0, 2'd1, 32'h0000_0003, 32'h0, 3, 5, "t2 write", rdo);
        check("t2 ctl_addr",    ctl_addr,    32'd1);
        check("t2 ctl_wr_data", ctl_wr_data, 32'h0000_0003);

        // Test 3: read
        cmd(0, 1, 2'd2, 32'h0, 32'hA5A5_0F0F, -1, 3, "t3 read", rdo);
        check("t3 readdata at ACK", rdo, 32'hA5A5_0F0F);

        // Write with done during the strobe cycle
        cmd(1, 0, 2'd0, 32'h1111_2222, 32'h0, 0, 2, "fast write", rdo);
        check("fast write readdata held", avs_readdata, 32'hA5A5_0F0F);

        // Test 4: timeout, then clear
        cmd(1, 0, 2'd3, 32'hFFFF_0000, 32'h0, -1, 2 + T, "t4 timeout", rdo);
        check("t4 err set", err, 1);
        pulse_clr();
        check("t4 err cleared", err, 0);

        // Test 5: simultaneous read and write
        cmd(1, 1, 2'd2, 32'h1234_5678, 32'hDEAD_BEEF, 0, 2, "t5 collide", rdo);
        check("t5 err set",        err,          1);
        check("t5 no read capture", avs_readdata, 32'hA5A5_0F0F);
        check("t5 wr_data",        ctl_wr_data,  32'h1234_5678);
        pulse_clr();

        // Test 6: back-to-back write then read with interrupt toggling
        irq_toggle = 1'b1;
        cmd(1, 0, 2'd0, 32'hCAFE_0001, 32'h0, 1, 3, "t6 write", rdo);
        cmd(0, 1, 2'd1, 32'h0, 32'h0BAD_F00D, -1, 3, "t6 read", rdo);
        check("t6 readdata", rdo, 32'h0BAD_F00D);
        repeat (4) @(posedge clk);
        irq_toggle = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
